// File: rtl/hazard_ctrl_unit.sv
// Forwarding, load-use, branch-flush and memory-wait freeze control for the 5-stage pipeline.
// Also produces a wait-timeout pulse and saturating stall counters.
module hazard_ctrl_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              store_id,
  input  logic [REG_AW-1:0] rs1_id_ex,
  input  logic [REG_AW-1:0] rs2_id_ex,
  input  logic [REG_AW-1:0] rd_id_ex,
  input  logic              reg_w_ena_id_ex,
  input  logic              ram_r_id_ex,
  input  logic              ram_w_id_ex,
  input  logic [REG_AW-1:0] rd_ex_mem,
  input  logic              reg_w_ena_ex_mem,
  input  logic              ram_r_ex_mem,
  input  logic              ram_w_ex_mem,
  input  logic [REG_AW-1:0] rd_mem_wb,
  input  logic              reg_w_ena_mem_wb,
  input  logic              ram_ready,
  input  logic              flush_ex,
  input  logic              cnt_clr,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              forward_c,
  output logic              stall_pc,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              bubble_id_ex,
  output logic              hold_id_ex,
  output logic              hold_ex_mem,
  output logic              bubble_mem_wb,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  mem_stall_cnt
);

  localparam int unsigned WC_W = $clog2(WAIT_MAX + 1);
  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]      state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            timeout_nxt;
  logic            hit_em_a, hit_em_b, hit_mw_a, hit_mw_b;
  logic            lu, mem_busy, at_limit, freeze, lu_apply;

  function automatic logic hit(input logic we, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] r);
    return we && (rd != '0) && (rd == r);
  endfunction

  // Operand forwarding; EX/MEM has priority over MEM/WB.
  assign hit_em_a  = hit(reg_w_ena_ex_mem, rd_ex_mem, rs1_id_ex);
  assign hit_em_b  = hit(reg_w_ena_ex_mem, rd_ex_mem, rs2_id_ex);
  assign hit_mw_a  = hit(reg_w_ena_mem_wb, rd_mem_wb, rs1_id_ex);
  assign hit_mw_b  = hit(reg_w_ena_mem_wb, rd_mem_wb, rs2_id_ex);
  assign forward_a = hit_em_a ? 2'b10 : (hit_mw_a ? 2'b01 : 2'b00);
  assign forward_b = hit_em_b ? 2'b10 : (hit_mw_b ? 2'b01 : 2'b00);
  assign forward_c = hit_em_b && !hit_em_a && ram_r_ex_mem && ram_w_id_ex;

  // A store consuming load data only as rs2 is served by forward_c instead of stalling.
  assign lu = ram_r_id_ex && reg_w_ena_id_ex && (rd_id_ex != '0) &&
              ((rs1_used_id && (rd_id_ex == rs1_id)) ||
               (rs2_used_id && (rd_id_ex == rs2_id) && !store_id));

  assign mem_busy = (ram_r_ex_mem || ram_w_ex_mem) && !ram_ready;
  assign at_limit = (state == ST_MEM_WAIT) && (wait_cnt == WC_W'(WAIT_MAX));
  // Gated by rst_n so a reset during a wait releases the pipeline immediately.
  assign freeze   = rst_n && mem_busy && !at_limit;

  always_comb begin
    state_nxt     = state;
    wait_nxt      = wait_cnt;
    timeout_nxt   = 1'b0;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_ex  = 1'b0;
    hold_id_ex    = 1'b0;
    hold_ex_mem   = 1'b0;
    bubble_mem_wb = 1'b0;
    lu_apply      = 1'b0;

    case (state)
      ST_RUN: begin
        if (freeze) begin
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_nxt = ST_RUN;
          wait_nxt  = '0;
        end else if (at_limit) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_RUN;
          wait_nxt    = '0;
        end else begin
          wait_nxt = wait_cnt + WC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wait_nxt  = '0;
      end
    endcase

    // Freeze masks flush and load-use; they take effect once it lifts.
    if (freeze) begin
      stall_pc      = 1'b1;
      stall_if_id   = 1'b1;
      hold_id_ex    = 1'b1;
      hold_ex_mem   = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (flush_ex) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (lu) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      lu_apply     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  // Saturating stall counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else if (cnt_clr) begin
      lu_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if (lu_apply && (lu_stall_cnt != CNT_MAX))
        lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
      if (freeze && (mem_stall_cnt != CNT_MAX))
        mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table, directed corner sequences
// and randomized cycles compared against a wait-age behavioural model.
module tb_hazard_ctrl_unit;

  localparam int REG_AW   = 5;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_AW-1:0] rs1_id, rs2_id, rs1_id_ex, rs2_id_ex, rd_id_ex, rd_ex_mem, rd_mem_wb;
  logic rs1_used_id, rs2_used_id, store_id;
  logic reg_w_ena_id_ex, ram_r_id_ex, ram_w_id_ex;
  logic reg_w_ena_ex_mem, ram_r_ex_mem, ram_w_ex_mem, reg_w_ena_mem_wb;
  logic ram_ready, flush_ex, cnt_clr;
  logic [1:0] forward_a, forward_b;
  logic forward_c, stall_pc, stall_if_id, flush_if_id, bubble_id_ex;
  logic hold_id_ex, hold_ex_mem, bubble_mem_wb, mem_timeout;
  logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt;

  int errors = 0;
  int checks = 0;

  // Model state: cycles the current access has been frozen, counters, pending timeout.
  int m_age = 0;
  int m_lu  = 0;
  int m_mem = 0;
  int m_to  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(REG_AW), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .store_id(store_id), .rs1_id_ex(rs1_id_ex), .rs2_id_ex(rs2_id_ex), .rd_id_ex(rd_id_ex),
    .reg_w_ena_id_ex(reg_w_ena_id_ex), .ram_r_id_ex(ram_r_id_ex), .ram_w_id_ex(ram_w_id_ex),
    .rd_ex_mem(rd_ex_mem), .reg_w_ena_ex_mem(reg_w_ena_ex_mem), .ram_r_ex_mem(ram_r_ex_mem),
    .ram_w_ex_mem(ram_w_ex_mem), .rd_mem_wb(rd_mem_wb), .reg_w_ena_mem_wb(reg_w_ena_mem_wb),
    .ram_ready(ram_ready), .flush_ex(flush_ex), .cnt_clr(cnt_clr),
    .forward_a(forward_a), .forward_b(forward_b), .forward_c(forward_c),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .hold_id_ex(hold_id_ex), .hold_ex_mem(hold_ex_mem),
    .bubble_mem_wb(bubble_mem_wb), .mem_timeout(mem_timeout),
    .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt)
  );

  typedef struct {
    logic [REG_AW-1:0] rs1x, rs2x, rdem, rdmw;
    logic weem, wemw, rrem, rwidex;
    logic [1:0] fa, fb;
    logic fc;
  } fv_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rs1_used_id = 0; rs2_used_id = 0; store_id = 0;
    rs1_id_ex = '0; rs2_id_ex = '0; rd_id_ex = '0;
    reg_w_ena_id_ex = 0; ram_r_id_ex = 0; ram_w_id_ex = 0;
    rd_ex_mem = '0; reg_w_ena_ex_mem = 0; ram_r_ex_mem = 0; ram_w_ex_mem = 0;
    rd_mem_wb = '0; reg_w_ena_mem_wb = 0;
    ram_ready = 1; flush_ex = 0; cnt_clr = 0;
  endtask

  function automatic int m_fwd(input int r);
    if (reg_w_ena_ex_mem && rd_ex_mem != 0 && int'(rd_ex_mem) == r) return 2;
    if (reg_w_ena_mem_wb && rd_mem_wb != 0 && int'(rd_mem_wb) == r) return 1;
    return 0;
  endfunction

  function automatic bit m_lu_hz();
    return ram_r_id_ex && reg_w_ena_id_ex && rd_id_ex != 0 &&
           ((rs1_used_id && rd_id_ex == rs1_id) ||
            (rs2_used_id && rd_id_ex == rs2_id && !store_id));
  endfunction

  function automatic bit m_busy();
    return (ram_r_ex_mem || ram_w_ex_mem) && !ram_ready;
  endfunction

  // An access may be frozen for at most WAIT_MAX cycles.
  function automatic bit m_freeze();
    return m_busy() && m_age < WAIT_MAX;
  endfunction

  // Compare every output against the model, away from the clock edge.
  task automatic eval();
    bit frz, lu, fc;
    @(negedge clk);
    frz = m_freeze();
    lu  = m_lu_hz();
    fc  = (m_fwd(int'(rs2_id_ex)) == 2) && (m_fwd(int'(rs1_id_ex)) != 2) &&
          ram_r_ex_mem && ram_w_id_ex;
    chk("m_forward_a", int'(forward_a), m_fwd(int'(rs1_id_ex)));
    chk("m_forward_b", int'(forward_b), m_fwd(int'(rs2_id_ex)));
    chk("m_forward_c", int'(forward_c), int'(fc));
    chk("m_stall_pc", int'(stall_pc), int'(frz || (!flush_ex && lu)));
    chk("m_stall_if_id", int'(stall_if_id), int'(frz || (!flush_ex && lu)));
    chk("m_flush_if_id", int'(flush_if_id), int'(!frz && flush_ex));
    chk("m_bubble_id_ex", int'(bubble_id_ex), int'(!frz && (flush_ex || lu)));
    chk("m_hold_id_ex", int'(hold_id_ex), int'(frz));
    chk("m_hold_ex_mem", int'(hold_ex_mem), int'(frz));
    chk("m_bubble_mem_wb", int'(bubble_mem_wb), int'(frz));
    chk("m_mem_timeout", int'(mem_timeout), m_to);
    chk("m_lu_stall_cnt", int'(lu_stall_cnt), m_lu);
    chk("m_mem_stall_cnt", int'(mem_stall_cnt), m_mem);
  endtask

  task automatic adv();
    bit frz, lu_app;
    @(posedge clk);
    frz    = m_freeze();
    lu_app = !frz && !flush_ex && m_lu_hz();
    m_to   = (m_busy() && m_age >= WAIT_MAX) ? 1 : 0;
    m_age  = frz ? m_age + 1 : 0;
    if (cnt_clr) begin
      m_lu = 0; m_mem = 0;
    end else begin
      if (lu_app && m_lu < CMAX) m_lu++;
      if (frz && m_mem < CMAX) m_mem++;
    end
    #1;
  endtask

  task automatic set_lu_add();
    ram_r_id_ex = 1; reg_w_ena_id_ex = 1; rd_id_ex = 5'd7;
    rs2_id = 5'd7; rs2_used_id = 1; rs1_id = 5'd2; rs1_used_id = 1;
  endtask

  task automatic do_clr();
    clear_inputs(); cnt_clr = 1; eval(); adv(); cnt_clr = 0;
  endtask

  fv_t tbl[8];
  int pre;

  initial begin
    tbl[0] = '{5'd5, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 2'b10, 2'b00, 0};
    tbl[1] = '{5'd5, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 2'b01, 2'b00, 0};
    tbl[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0};
    tbl[3] = '{5'd3, 5'd4, 5'd4, 5'd3, 1, 1, 0, 0, 2'b01, 2'b10, 0};
    tbl[4] = '{5'd3, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1, 2'b00, 2'b10, 1};
    tbl[5] = '{5'd4, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1, 2'b10, 2'b10, 0};
    tbl[6] = '{5'd6, 5'd6, 5'd1, 5'd6, 1, 0, 0, 0, 2'b00, 2'b00, 0};
    tbl[7] = '{5'd9, 5'd9, 5'd0, 5'd9, 1, 1, 0, 0, 2'b01, 2'b01, 0};

    clear_inputs();
    rst_n = 0;
    ram_r_ex_mem = 1; ram_ready = 0;
    #3;
    chk("reset_mem_timeout", int'(mem_timeout), 0);
    chk("reset_lu_cnt", int'(lu_stall_cnt), 0);
    chk("reset_mem_cnt", int'(mem_stall_cnt), 0);
    chk("reset_hold_ex_mem", int'(hold_ex_mem), 0);
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1;

    // Forwarding vector table.
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      rs1_id_ex = tbl[i].rs1x; rs2_id_ex = tbl[i].rs2x;
      rd_ex_mem = tbl[i].rdem; rd_mem_wb = tbl[i].rdmw;
      reg_w_ena_ex_mem = tbl[i].weem; reg_w_ena_mem_wb = tbl[i].wemw;
      ram_r_ex_mem = tbl[i].rrem; ram_w_id_ex = tbl[i].rwidex;
      eval();
      chk($sformatf("tbl%0d_forward_a", i), int'(forward_a), int'(tbl[i].fa));
      chk($sformatf("tbl%0d_forward_b", i), int'(forward_b), int'(tbl[i].fb));
      chk($sformatf("tbl%0d_forward_c", i), int'(forward_c), int'(tbl[i].fc));
      adv();
    end

    // Load-use on add, then store matching only on rs2, then forward_c next cycle.
    do_clr();
    set_lu_add();
    eval();
    chk("lu_stall_pc", int'(stall_pc), 1);
    chk("lu_stall_if_id", int'(stall_if_id), 1);
    chk("lu_bubble_id_ex", int'(bubble_id_ex), 1);
    adv();
    chk("lu_cnt_one", int'(lu_stall_cnt), 1);
    clear_inputs();
    ram_r_id_ex = 1; reg_w_ena_id_ex = 1; rd_id_ex = 5'd7;
    store_id = 1; rs1_id = 5'd3; rs1_used_id = 1; rs2_id = 5'd7; rs2_used_id = 1;
    eval();
    chk("store_no_stall", int'(stall_pc), 0);
    chk("store_no_bubble", int'(bubble_id_ex), 0);
    adv();
    clear_inputs();
    rd_ex_mem = 5'd7; reg_w_ena_ex_mem = 1; ram_r_ex_mem = 1;
    rs1_id_ex = 5'd3; rs2_id_ex = 5'd7; ram_w_id_ex = 1;
    eval();
    chk("store_forward_c", int'(forward_c), 1);
    adv();

    // Flush and load-use together: flush wins, no lu count.
    clear_inputs();
    set_lu_add(); flush_ex = 1;
    pre = int'(lu_stall_cnt);
    eval();
    chk("flush_flush_if_id", int'(flush_if_id), 1);
    chk("flush_bubble_id_ex", int'(bubble_id_ex), 1);
    chk("flush_stall_pc", int'(stall_pc), 0);
    adv();
    chk("flush_lu_cnt", int'(lu_stall_cnt), pre);

    // Three wait cycles then ready.
    do_clr();
    ram_r_ex_mem = 1; ram_ready = 0;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk($sformatf("wait3_hold_c%0d", i), int'(hold_ex_mem), 1);
      adv();
    end
    ram_ready = 1;
    eval();
    chk("wait3_ready_hold", int'(hold_ex_mem), 0);
    chk("wait3_ready_stall", int'(stall_pc), 0);
    adv();
    chk("wait3_mem_cnt", int'(mem_stall_cnt), 3);
    clear_inputs();
    eval(); adv();

    // Timeout: frozen WAIT_MAX cycles, released next, pulse the cycle after.
    do_clr();
    ram_r_ex_mem = 1; ram_ready = 0;
    for (int i = 0; i < WAIT_MAX; i++) begin
      eval();
      chk($sformatf("to_freeze_c%0d", i), int'(hold_id_ex), 1);
      chk($sformatf("to_pulse_early_c%0d", i), int'(mem_timeout), 0);
      adv();
    end
    eval();
    chk("to_release", int'(hold_id_ex), 0);
    chk("to_pulse_not_yet", int'(mem_timeout), 0);
    adv();
    clear_inputs();
    eval();
    chk("to_pulse", int'(mem_timeout), 1);
    adv();
    eval();
    chk("to_pulse_end", int'(mem_timeout), 0);
    adv();

    // Reset in the middle of a second wait.
    ram_r_ex_mem = 1; ram_ready = 0;
    eval(); adv();
    eval(); adv();
    #2;
    rst_n = 0;
    #1;
    chk("rst_hold_ex_mem", int'(hold_ex_mem), 0);
    chk("rst_stall_pc", int'(stall_pc), 0);
    chk("rst_bubble_mem_wb", int'(bubble_mem_wb), 0);
    chk("rst_mem_cnt", int'(mem_stall_cnt), 0);
    chk("rst_lu_cnt", int'(lu_stall_cnt), 0);
    m_age = 0; m_lu = 0; m_mem = 0; m_to = 0;
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1;

    // lu counter saturation and clear.
    clear_inputs();
    set_lu_add();
    for (int i = 0; i < 20; i++) begin
      eval(); adv();
    end
    chk("sat_lu_cnt", int'(lu_stall_cnt), CMAX);
    cnt_clr = 1;
    eval(); adv();
    chk("clr_lu_cnt", int'(lu_stall_cnt), 0);

    // Randomized cycles against the model.
    for (int n = 0; n < 600; n++) begin
      rs1_id = REG_AW'($urandom_range(0, 3)); rs2_id = REG_AW'($urandom_range(0, 3));
      rs1_used_id = 1'($urandom); rs2_used_id = 1'($urandom); store_id = 1'($urandom);
      rs1_id_ex = REG_AW'($urandom_range(0, 3)); rs2_id_ex = REG_AW'($urandom_range(0, 3));
      rd_id_ex = REG_AW'($urandom_range(0, 3));
      reg_w_ena_id_ex = 1'($urandom); ram_r_id_ex = 1'($urandom); ram_w_id_ex = 1'($urandom);
      rd_ex_mem = REG_AW'($urandom_range(0, 3)); reg_w_ena_ex_mem = 1'($urandom);
      ram_r_ex_mem = ($urandom_range(0, 3) == 0); ram_w_ex_mem = ($urandom_range(0, 5) == 0);
      rd_mem_wb = REG_AW'($urandom_range(0, 3)); reg_w_ena_mem_wb = 1'($urandom);
      ram_ready = ($urandom_range(0, 9) < 3);
      flush_ex = ($urandom_range(0, 5) == 0);
      cnt_clr = ($urandom_range(0, 40) == 0);
      eval(); adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
